// File: rtl/arb_req_agent_pkg.sv
// ---------------------------------------------------------------------------
// arb_req_pkg
// Shared types and default parameters for the arbiter requester agent.
//   state_t          : agent FSM state encoding (IDLE / XFER)
//   DEF_*            : default values for the agent parameters
//   idx_w()          : width of a client index (at least 1 bit)
// ---------------------------------------------------------------------------
package arb_req_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam int DEF_NUM_CLIENTS = 4;
    localparam int DEF_CNT_W       = 4;
    localparam int DEF_HOLD_CYCLES = 2;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_req_agent_if.sv
// ---------------------------------------------------------------------------
// arb_req_agent_if
// Bundles the client job handshake, the arbiter req/gnt handshake and the
// agent status outputs.
//   master : the agent (drives req, job_ready, busy, owner, xfer_done, gnt_err)
//   slave  : the environment (drives job_valid and gnt)
// ---------------------------------------------------------------------------
interface arb_req_agent_if
    import arb_req_pkg::*;
#(
    parameter int NUM_CLIENTS = DEF_NUM_CLIENTS
);
    localparam int OW = idx_w(NUM_CLIENTS);

    logic [NUM_CLIENTS-1:0] job_valid;
    logic [NUM_CLIENTS-1:0] job_ready;
    logic [NUM_CLIENTS-1:0] req;
    logic [NUM_CLIENTS-1:0] gnt;
    logic                   busy;
    logic [OW-1:0]          owner;
    logic [NUM_CLIENTS-1:0] xfer_done;
    logic                   gnt_err;

    modport master (
        input  job_valid, gnt,
        output job_ready, req, busy, owner, xfer_done, gnt_err
    );

    modport slave (
        output job_valid, gnt,
        input  job_ready, req, busy, owner, xfer_done, gnt_err
    );

endinterface

// File: rtl/arb_req_agent_client_pend_ctr.sv
// ---------------------------------------------------------------------------
// client_pend_ctr
// Pending-job counter for one client. Saturation is the caller's job: inc is
// only asserted when not full, dec only when nonzero.
//   clk, rst : clock, async active-low reset
//   inc, dec : add / retire one job (both together leave the count unchanged)
//   full     : count is at 2^CNT_W-1
//   nonzero  : at least one job pending
// ---------------------------------------------------------------------------
module client_pend_ctr #(
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic nonzero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign full    = &cnt;
    assign nonzero = |cnt;

endmodule

// File: rtl/arb_req_agent.sv
// ---------------------------------------------------------------------------
// arb_req_agent
// Requester side of the req/gnt arbiter handshake. Queues client jobs in
// per-client counters, requests for every client with pending work, and on a
// legal one-hot grant runs a HOLD_CYCLES-long transfer for that client, then
// retires one of its jobs.
//   clk       : clock
//   rst       : async active-low reset
//   bus       : arb_req_agent_if.master (job_valid/job_ready, req/gnt,
//               busy, owner, xfer_done, gnt_err)
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | req mirrors pending jobs; waiting for a legal grant
//   XFER  | transfer for owner in progress; req holds owner, gnt ignored
// ---------------------------------------------------------------------------
module arb_req_agent
    import arb_req_pkg::*;
#(
    parameter int NUM_CLIENTS = DEF_NUM_CLIENTS,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    arb_req_agent_if.master      bus
);

    localparam int OW = idx_w(NUM_CLIENTS);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t                 state;
    logic [OW-1:0]          owner_q;
    logic [HW-1:0]          hold_q;
    logic [NUM_CLIENTS-1:0] done_q;
    logic                   err_q;

    logic [NUM_CLIENTS-1:0] full;
    logic [NUM_CLIENTS-1:0] nonzero;
    logic [NUM_CLIENTS-1:0] inc;
    logic [NUM_CLIENTS-1:0] dec;
    logic [NUM_CLIENTS-1:0] owner_oh;
    logic                   retire;

    logic [OW-1:0]          gnt_idx;
    logic                   gnt_legal;

    assign owner_oh = {{(NUM_CLIENTS-1){1'b0}}, 1'b1} << owner_q;
    assign retire   = (state == XFER) && (hold_q == '0);
    assign inc      = bus.job_valid & ~full;
    assign dec      = retire ? owner_oh : '0;

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_pend
        client_pend_ctr #(
            .CNT_W   (CNT_W)
        ) u_pend (
            .clk     (clk),
            .rst     (rst),
            .inc     (inc[i]),
            .dec     (dec[i]),
            .full    (full[i]),
            .nonzero (nonzero[i])
        );
    end

    // In IDLE req equals nonzero, so "granted bit is requested" and "granted
    // client has pending work" reduce to the same test.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (bus.gnt[i]) begin
                gnt_idx = OW'(i);
            end
        end
        gnt_legal = $onehot(bus.gnt) && |(bus.gnt & nonzero);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            owner_q <= '0;
            hold_q  <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            done_q <= '0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_legal) begin
                        state   <= XFER;
                        owner_q <= gnt_idx;
                        hold_q  <= HW'(HOLD_CYCLES - 1);
                    end else if (|bus.gnt) begin
                        err_q <= 1'b1;
                    end
                end
                XFER: begin
                    if (hold_q == '0) begin
                        state  <= IDLE;
                        done_q <= owner_oh;
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req       = (state == XFER) ? owner_oh : nonzero;
    assign bus.job_ready = ~full;
    assign bus.busy      = (state == XFER);
    assign bus.owner     = owner_q;
    assign bus.xfer_done = done_q;
    assign bus.gnt_err   = err_q;

endmodule

// File: tb/tb_arb_req_agent.sv
// ---------------------------------------------------------------------------
// tb_arb_req_agent
// Directed scenarios with literal expectations, then randomized job/grant
// traffic. A behavioural model (pending job counts, a transfer countdown)
// predicts every output and is compared on each falling edge.
// ---------------------------------------------------------------------------
module tb_arb_req_agent;

    localparam int N    = 4;
    localparam int CW   = 4;
    localparam int HOLD = 2;
    localparam int MAXP = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    arb_req_agent_if #(.NUM_CLIENTS(N)) bus ();

    arb_req_agent #(
        .NUM_CLIENTS (N),
        .CNT_W       (CW),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int       pend [N];
    bit       m_busy;
    int       m_owner;
    int       m_left;
    bit [3:0] m_done;
    bit       m_err;

    task automatic model_reset();
        for (int i = 0; i < N; i++) pend[i] = 0;
        m_busy  = 0;
        m_owner = 0;
        m_left  = 0;
        m_done  = '0;
        m_err   = 0;
    endtask

    function automatic bit [3:0] exp_req();
        bit [3:0] r;
        r = '0;
        if (m_busy) r[m_owner] = 1'b1;
        else for (int i = 0; i < N; i++) r[i] = (pend[i] != 0);
        return r;
    endfunction

    function automatic bit [3:0] exp_ready();
        bit [3:0] r;
        for (int i = 0; i < N; i++) r[i] = (pend[i] != MAXP);
        return r;
    endfunction

    task automatic model_step(input logic [3:0] jv, input logic [3:0] g);
        bit [3:0] acc;
        int       ret;
        int       ones;
        int       k;
        ret    = -1;
        m_done = '0;
        m_err  = 0;
        for (int i = 0; i < N; i++) acc[i] = jv[i] && (pend[i] != MAXP);
        if (!m_busy) begin
            if (g != 0) begin
                ones = 0;
                k    = 0;
                for (int i = 0; i < N; i++) if (g[i]) begin ones++; k = i; end
                if (ones == 1 && pend[k] > 0) begin
                    m_busy  = 1;
                    m_owner = k;
                    m_left  = HOLD;
                end else begin
                    m_err = 1;
                end
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_busy          = 0;
                m_done[m_owner] = 1'b1;
                ret             = m_owner;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (acc[i]) pend[i]++;
            if (ret == i) pend[i]--;
        end
    endtask

    // Compare process: outputs are stable at the falling edge.
    initial model_reset();

    always @(negedge clk) begin
        if (!rst) model_reset();
        chk("m_req",       32'(bus.req),       32'(exp_req()));
        chk("m_job_ready", 32'(bus.job_ready), 32'(exp_ready()));
        chk("m_busy",      32'(bus.busy),      32'(m_busy));
        chk("m_owner",     32'(bus.owner),     32'(m_owner));
        chk("m_xfer_done", 32'(bus.xfer_done), 32'(m_done));
        chk("m_gnt_err",   32'(bus.gnt_err),   32'(m_err));
        if (rst) model_step(bus.job_valid, bus.gnt);
    end

    // ---------------- stimulus ----------------
    // Inputs change 2 units after a rising edge and are sampled at the next one.
    task automatic cyc(input logic [3:0] jv, input logic [3:0] g);
        @(posedge clk);
        #2;
        bus.job_valid = jv;
        bus.gnt       = g;
    endtask

    initial begin
        logic [3:0] jv;
        logic [3:0] g;
        bus.job_valid = 4'b1111;
        bus.gnt       = 4'b0000;
        rst           = 1'b0;

        // Reset holds everything regardless of job_valid.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req",       32'(bus.req),       32'h0);
        chk("rst_busy",      32'(bus.busy),      32'h0);
        chk("rst_job_ready", 32'(bus.job_ready), 32'hf);
        chk("rst_xfer_done", 32'(bus.xfer_done), 32'h0);
        chk("rst_gnt_err",   32'(bus.gnt_err),   32'h0);
        chk("rst_owner",     32'(bus.owner),     32'h0);
        #1;
        rst           = 1'b1;
        bus.job_valid = 4'b0101;
        cyc(4'b0000, 4'b0000);
        chk("first_req", 32'(bus.req), 32'h5);

        // Basic transfer on client 0.
        cyc(4'b0000, 4'b0001);
        cyc(4'b0000, 4'b0000);
        chk("xfer_busy0",  32'(bus.busy),  32'h1);
        chk("xfer_req",    32'(bus.req),   32'h1);
        chk("xfer_owner",  32'(bus.owner), 32'h0);
        cyc(4'b0000, 4'b0000);
        chk("xfer_busy1",  32'(bus.busy),      32'h1);
        chk("xfer_nodone", 32'(bus.xfer_done), 32'h0);
        cyc(4'b0000, 4'b0000);
        chk("xfer_idle",   32'(bus.busy),      32'h0);
        chk("xfer_done",   32'(bus.xfer_done), 32'h1);
        chk("xfer_req_after", 32'(bus.req),    32'h4);
        cyc(4'b0000, 4'b0000);
        chk("done_pulse_end", 32'(bus.xfer_done), 32'h0);

        // Illegal grants in IDLE.
        cyc(4'b0010, 4'b0000);
        cyc(4'b0000, 4'b1000);
        chk("illegal_req", 32'(bus.req), 32'h6);
        cyc(4'b0000, 4'b0000);
        chk("err_unreq",      32'(bus.gnt_err), 32'h1);
        chk("err_unreq_busy", 32'(bus.busy),    32'h0);
        cyc(4'b0000, 4'b0011);
        chk("err_pulse_end", 32'(bus.gnt_err), 32'h0);
        cyc(4'b0000, 4'b0000);
        chk("err_multi",      32'(bus.gnt_err), 32'h1);
        chk("err_multi_busy", 32'(bus.busy),    32'h0);

        // Fill client 3, then retire while it is full.
        for (int i = 0; i < MAXP; i++) cyc(4'b1000, 4'b0000);
        cyc(4'b1000, 4'b0000);
        chk("full_ready", 32'(bus.job_ready), 32'h7);
        cyc(4'b0000, 4'b1000);
        chk("full_drop_ready", 32'(bus.job_ready), 32'h7);
        chk("full_req",        32'(bus.req),       32'he);
        cyc(4'b0000, 4'b0000);
        chk("full_owner", 32'(bus.owner), 32'h3);
        cyc(4'b1000, 4'b0000);
        cyc(4'b0000, 4'b0000);
        chk("full_retire_done",  32'(bus.xfer_done), 32'h8);
        chk("full_retire_ready", 32'(bus.job_ready), 32'hf);
        // At 14: accept and retire on the same edge leaves the count alone.
        cyc(4'b0000, 4'b1000);
        cyc(4'b0000, 4'b0000);
        cyc(4'b1000, 4'b0000);
        cyc(4'b0000, 4'b0000);
        chk("same_edge_done",  32'(bus.xfer_done), 32'h8);
        chk("same_edge_ready", 32'(bus.job_ready), 32'hf);
        cyc(4'b1000, 4'b0000);
        cyc(4'b0000, 4'b0000);
        chk("refill_ready", 32'(bus.job_ready), 32'h7);

        // Grant moves during a transfer for client 0.
        cyc(4'b0001, 4'b0000);
        cyc(4'b0000, 4'b0001);
        cyc(4'b0000, 4'b1000);
        chk("hold_busy",  32'(bus.busy),  32'h1);
        chk("hold_owner", 32'(bus.owner), 32'h0);
        cyc(4'b0000, 4'b1000);
        chk("hold_owner2", 32'(bus.owner),   32'h0);
        chk("hold_noerr",  32'(bus.gnt_err), 32'h0);
        chk("hold_req",    32'(bus.req),     32'h1);
        cyc(4'b0000, 4'b0000);
        chk("hold_done",   32'(bus.xfer_done), 32'h1);
        chk("hold_noerr2", 32'(bus.gnt_err),   32'h0);

        // Reset in the middle of a transfer.
        cyc(4'b0000, 4'b0010);
        cyc(4'b0000, 4'b0000);
        chk("pre_rst_busy", 32'(bus.busy), 32'h1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_busy",  32'(bus.busy),      32'h0);
        chk("midrst_req",   32'(bus.req),       32'h0);
        chk("midrst_done",  32'(bus.xfer_done), 32'h0);
        chk("midrst_ready", 32'(bus.job_ready), 32'hf);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        cyc(4'b0000, 4'b0000);
        cyc(4'b0000, 4'b0000);
        chk("postrst_req",  32'(bus.req),       32'h0);
        chk("postrst_done", 32'(bus.xfer_done), 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #2;
            if (n == 1500 || $urandom_range(0, 599) == 0) begin
                rst = 1'b0;
                repeat (2) @(posedge clk);
                #2;
                rst = 1'b1;
            end
            jv = 4'($urandom) & 4'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2: g = 4'b0000;
                3, 4, 5, 6: begin
                    g = 4'b0000;
                    if (bus.req != 4'b0000) begin
                        for (int t = 0; t < 16 && g == 4'b0000; t++) begin
                            int b;
                            b = $urandom_range(0, N - 1);
                            if (bus.req[b]) g[b] = 1'b1;
                        end
                    end
                end
                7, 8: g = 4'b0001 << $urandom_range(0, N - 1);
                default: g = 4'($urandom);
            endcase
            bus.job_valid = jv;
            bus.gnt       = g;
        end

        cyc(4'b0000, 4'b0000);
        cyc(4'b0000, 4'b0000);
        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
